// File: rtl/if_prefetch_buf_pkg.sv
// if_prefetch_buf_pkg: shared reset pc default, fetch-entry struct {pc, inst, adef} and its bit width
package if_prefetch_buf_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;
  localparam int FE_W = $bits(fetch_entry_t);
endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous circular FIFO; clk/resetn, clr flush, push/din, pop/dout, count/empty/full status
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           clr,
  input  logic                           push,
  input  logic [W-1:0]                   din,
  input  logic                           pop,
  output logic [W-1:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (!resetn || clr) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (resetn && !clr && push) assert (!full || do_pop);
endmodule

// File: rtl/if_prefetch_buf.sv
// if_prefetch_buf: instruction prefetch with OUTST in-flight fetches, redirects (ex>ertn>br) on ex_*/ertn_*/br_*, sram_* fetch port, out_* decode stream with adef
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int          OUTST = 4,
  parameter int          IBUF_DEPTH = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_flush,
  input  logic [31:0] ex_pc,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        sram_req,
  output logic [31:0] sram_addr,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adef
);
  localparam int OW = $clog2(OUTST + 1);
  localparam int FW = $clog2(IBUF_DEPTH + 1);
  logic redirect, issue, drop, push_data, push_adef, misal, stall, pend_v;
  logic q_empty, q_full, f_empty, f_full;
  logic [31:0] redir_pc, pend_pc, fetch_pc, q_pc;
  logic [OW-1:0] inflight, discard_cnt;
  logic [FW-1:0] fcnt;
  fetch_entry_t f_din, f_dout;
  assign redirect = ex_flush | ertn_flush | br_taken;
  assign redir_pc = ex_flush ? ex_pc : ertn_flush ? ertn_pc : br_target;
  assign sram_addr = pend_v ? pend_pc : fetch_pc;
  assign misal = sram_addr[1:0] != 2'b00;
  assign sram_req = resetn & ~q_full & ~misal & (32'(inflight) + 32'(fcnt) < 32'(IBUF_DEPTH));
  assign issue = sram_req & sram_addr_ok;
  assign drop = redirect | (discard_cnt != '0);
  assign push_data = sram_data_ok & ~drop;
  assign push_adef = misal & ~stall & ~redirect & q_empty & ~f_full;
  assign f_din = push_adef ? fetch_entry_t'{pc: sram_addr, inst: 32'd0, adef: 1'b1}
                           : fetch_entry_t'{pc: q_pc, inst: sram_rdata, adef: 1'b0};
  assign out_valid = ~f_empty & ~redirect;
  assign out_pc = f_dout.pc;
  assign out_inst = f_dout.inst;
  assign out_adef = f_dout.adef;
  always_ff @(posedge clk)
    if (!resetn) begin
      pend_v <= 1'b1;
      pend_pc <= RESET_PC;
      fetch_pc <= RESET_PC;
      discard_cnt <= '0;
      stall <= 1'b0;
    end else if (redirect) begin
      pend_v <= 1'b1;
      pend_pc <= redir_pc;
      fetch_pc <= redir_pc;
      discard_cnt <= inflight + OW'(issue) - OW'(sram_data_ok);
      stall <= 1'b0;
    end else begin
      if (issue) begin
        pend_v <= 1'b0;
        fetch_pc <= sram_addr + 32'd4;
      end
      if (sram_data_ok && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
      if (push_adef) stall <= 1'b1;
    end
  if_fifo #(.DEPTH(OUTST), .W(32)) u_pcq (
    .clk(clk), .resetn(resetn), .clr(1'b0),
    .push(issue), .din(sram_addr), .pop(sram_data_ok), .dout(q_pc),
    .count(inflight), .empty(q_empty), .full(q_full)
  );
  if_fifo #(.DEPTH(IBUF_DEPTH), .W(FE_W)) u_ibuf (
    .clk(clk), .resetn(resetn), .clr(redirect),
    .push(push_data | push_adef), .din(f_din), .pop(out_valid & out_ready), .dout(f_dout),
    .count(fcnt), .empty(f_empty), .full(f_full)
  );
endmodule

// File: tb/tb_if_prefetch_buf.sv
// tb_if_prefetch_buf: randomized bench comparing the decode stream against an in-order program-flow model
module tb_if_prefetch_buf;
  localparam int OUTST = 4;
  localparam int IBUF_DEPTH = 4;
  logic clk = 1'b0, resetn = 1'b0;
  logic ex_flush = 1'b0, ertn_flush = 1'b0, br_taken = 1'b0;
  logic [31:0] ex_pc = '0, ertn_pc = '0, br_target = '0;
  logic sram_req, sram_addr_ok = 1'b0, sram_data_ok = 1'b0;
  logic [31:0] sram_addr, sram_rdata = '0;
  logic out_valid, out_ready = 1'b0, out_adef;
  logic [31:0] out_pc, out_inst;
  always #5 clk = ~clk;
  if_prefetch_buf #(.OUTST(OUTST), .IBUF_DEPTH(IBUF_DEPTH), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .resetn(resetn),
    .ex_flush(ex_flush), .ex_pc(ex_pc), .ertn_flush(ertn_flush), .ertn_pc(ertn_pc),
    .br_taken(br_taken), .br_target(br_target),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_adef(out_adef)
  );
  typedef struct {
    logic [31:0] a;
    int due;
  } req_t;
  req_t mq[$];
  int n_vec = 0, n_err = 0, cyc = 0, delivered = 0, max_out = 0;
  int aok_pct = 100, dok_pct = 100, rdy_pct = 100, lat = 1;
  int first_req_cyc = -1, first_vld_cyc = -1;
  logic [31:0] exp_pc = 32'h1c000000, last_pc = '0, hold_addr = '0;
  logic exp_stall = 1'b0, mis_mode = 1'b0, hold_armed = 1'b0, was_rst = 1'b1, track = 1'b0;
  logic last_vld = 1'b0, last_req = 1'b0;
  logic p_rst = 1'b1, p_ex = 1'b0, p_ertn = 1'b0, p_br = 1'b0, p_need_dok = 1'b0;
  logic [31:0] p_ex_pc = '0, p_ertn_pc = '0, p_br_pc = '0;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00000013;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    logic redir;
    @(negedge clk);
    resetn = !p_rst;
    sram_addr_ok = $urandom_range(99) < aok_pct;
    sram_data_ok = 1'b0;
    sram_rdata = $urandom;
    if (mq.size() != 0)
      if (mq[0].due <= cyc && $urandom_range(99) < dok_pct) begin
        sram_data_ok = 1'b1;
        sram_rdata = inst_of(mq[0].a);
      end
    out_ready = $urandom_range(99) < rdy_pct;
    redir = resetn && (p_ex || p_ertn || p_br) && (!p_need_dok || sram_data_ok);
    ex_flush = redir & p_ex;
    ertn_flush = redir & p_ertn;
    br_taken = redir & p_br;
    ex_pc = p_ex_pc;
    ertn_pc = p_ertn_pc;
    br_target = p_br_pc;
    #1;
    last_vld = out_valid;
    last_req = sram_req;
    if (!resetn) begin
      if (cyc > 0) begin
        check("rst_req", 32'(sram_req), 0);
        check("rst_vld", 32'(out_valid), 0);
      end
      mq.delete();
      hold_armed = 1'b0;
      exp_pc = 32'h1c000000;
      exp_stall = 1'b0;
      mis_mode = 1'b0;
      p_ex = 1'b0;
      p_ertn = 1'b0;
      p_br = 1'b0;
      p_need_dok = 1'b0;
    end else begin
      if (was_rst) check("first_addr", sram_addr, 32'h1c000000);
      if (redir) check("vld_on_redir", 32'(out_valid), 0);
      if (hold_armed) begin
        check("req_hold", 32'(sram_req), 1);
        check("addr_hold", sram_addr, hold_addr);
      end
      if (mq.size() >= OUTST) check("req_outst", 32'(sram_req), 0);
      if (mis_mode) check("req_misal", 32'(sram_req), 0);
      if (sram_req) check("req_align", 32'(sram_addr[1:0]), 0);
      if (exp_stall && !redir) check("adef_stall", 32'(out_valid), 0);
      else if (out_valid && out_ready) begin
        check("pc", out_pc, exp_pc);
        check("adef", 32'(out_adef), 32'(exp_pc[1:0] != 2'b00));
        check("inst", out_inst, exp_pc[1:0] != 2'b00 ? 32'd0 : inst_of(exp_pc));
        if (exp_pc[1:0] != 2'b00) exp_stall = 1'b1;
        else exp_pc = exp_pc + 32'd4;
        delivered++;
        last_pc = out_pc;
      end
      if (sram_data_ok) void'(mq.pop_front());
      if (sram_req && sram_addr_ok) mq.push_back('{a: sram_addr, due: cyc + lat});
      if (mq.size() > max_out) max_out = mq.size();
      hold_armed = sram_req && !sram_addr_ok && !redir;
      hold_addr = sram_addr;
      if (track) begin
        if (first_req_cyc < 0 && sram_req) first_req_cyc = cyc;
        if (first_vld_cyc < 0 && out_valid) first_vld_cyc = cyc;
      end
      if (redir) begin
        exp_pc = p_ex ? p_ex_pc : p_ertn ? p_ertn_pc : p_br_pc;
        exp_stall = 1'b0;
        mis_mode = exp_pc[1:0] != 2'b00;
        p_ex = 1'b0;
        p_ertn = 1'b0;
        p_br = 1'b0;
        p_need_dok = 1'b0;
      end
    end
    was_rst = !resetn;
    @(posedge clk);
    cyc++;
  endtask
  task automatic run_until(input int n, input int budget);
    int start;
    start = delivered;
    for (int k = 0; k < budget && delivered - start < n; k++) step();
    check("progress", 32'(delivered - start), 32'(n));
  endtask
  task automatic set_knobs(input int a, input int d, input int r, input int l);
    aok_pct = a;
    dok_pct = d;
    rdy_pct = r;
    lat = l;
  endtask
  initial begin
    int d0;
    int k;
    repeat (3) step();
    p_rst = 1'b0;
    set_knobs(100, 100, 100, 1);
    run_until(8, 200);
    check("boot_seq", last_pc, 32'h1c00001c);
    p_br = 1'b1;
    p_br_pc = 32'h1c000400;
    step();
    first_req_cyc = -1;
    first_vld_cyc = -1;
    track = 1'b1;
    repeat (5) step();
    d0 = delivered;
    repeat (20) step();
    track = 1'b0;
    check("latency", 32'(first_vld_cyc - first_req_cyc), 2);
    check("throughput", 32'(delivered - d0), 20);
    set_knobs(100, 100, 100, 4);
    max_out = 0;
    repeat (30) step();
    check("max_outst", 32'(max_out), OUTST);
    set_knobs(100, 100, 100, 6);
    k = 0;
    while (mq.size() != 3 && k < 50) begin
      step();
      k++;
    end
    check("three_inflight", 32'(mq.size()), 3);
    p_br = 1'b1;
    p_br_pc = 32'h1c000100;
    step();
    run_until(1, 100);
    check("br_pc", last_pc, 32'h1c000100);
    set_knobs(100, 100, 100, 2);
    repeat (6) step();
    p_ex = 1'b1;
    p_ex_pc = 32'h1c008000;
    p_br = 1'b1;
    p_br_pc = 32'h1c000200;
    p_need_dok = 1'b1;
    run_until(1, 100);
    check("ex_pc", last_pc, 32'h1c008000);
    set_knobs(100, 100, 100, 1);
    p_br = 1'b1;
    p_br_pc = 32'h1c000102;
    run_until(1, 100);
    check("adef_pc", last_pc, 32'h1c000102);
    d0 = delivered;
    repeat (15) step();
    check("adef_hold", 32'(delivered - d0), 0);
    p_br = 1'b1;
    p_br_pc = 32'h1c000300;
    run_until(4, 100);
    rdy_pct = 0;
    repeat (10) step();
    check("fill_vld", 32'(last_vld), 1);
    check("fill_noreq", 32'(last_req), 0);
    set_knobs(0, 100, 100, 1);
    d0 = delivered;
    repeat (8) step();
    check("fill_cnt", 32'(delivered - d0), IBUF_DEPTH);
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0)
        set_knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(5, 1));
      if (i == 750) begin
        p_rst = 1'b1;
        repeat (3) step();
        p_rst = 1'b0;
      end
      if (!p_ex && !p_ertn && !p_br && $urandom_range(39) == 0) begin
        logic [2:0] f;
        f = 3'($urandom_range(7, 1));
        {p_ex, p_ertn, p_br} = f;
        p_ex_pc = $urandom & 32'hfffffffc;
        p_ertn_pc = $urandom & 32'hfffffffc;
        p_br_pc = $urandom_range(15) == 0 ? 32'hfffffff8 : $urandom & 32'hfffffffc;
        if ($urandom_range(7) == 0) p_br_pc[1] = 1'b1;
        if ($urandom_range(7) == 0) p_ex_pc[0] = 1'b1;
        p_need_dok = mq.size() != 0 && $urandom_range(2) == 0;
      end
      step();
    end
    set_knobs(100, 100, 100, 1);
    p_ertn = 1'b1;
    p_ertn_pc = 32'h1c00a000;
    run_until(6, 300);
    check("final_pc", last_pc, 32'h1c00a014);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
